// File: rtl/maquina_maluca.sv
// -----------------------------------------------------------------------------
// maquina_maluca
// Sequencing FSM for an automatic coffee machine. A brew request seen in IDLE
// walks the machine through power-on, water check, optional reservoir fill,
// grind, filter, stir, lid and extraction, then back to IDLE. Every non-IDLE
// state lasts exactly one clock.
//
// An internal reservoir-full flag (agua_cheia_r) decides whether the fill step
// is taken. After a fill the flag stays set, so later brews skip the fill.
//
// Optional feature: define CONSUMO_AGUA_EN to clear the reservoir flag when
// leaving REALIZAR_EXTRACAO. With it defined, every brew cycle refills.
//
// Parameters:
//   AGUA_INICIAL - reset value of the reservoir-full flag (0 empty, 1 full)
//
// Ports:
//   clk   in   1  system clock, rising-edge active
//   rst   in   1  asynchronous active-high reset (state -> IDLE, flag reload)
//   start in   1  brew request, sampled only while in IDLE
//   state out  4  current state code, driven directly by the state register
// -----------------------------------------------------------------------------
module maquina_maluca #(
  parameter logic AGUA_INICIAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] state
);

  // Fixed state encoding; codes 0 and 10-15 are unused and recover to IDLE.
  typedef enum logic [3:0] {
    IDLE                = 4'd1,
    LIGAR_MAQUINA       = 4'd2,
    VERIFICAR_AGUA      = 4'd3,
    ENCHER_RESERVATORIO = 4'd4,
    MOER_CAFE           = 4'd5,
    COLOCAR_NO_FILTRO   = 4'd6,
    PASSAR_AGITADOR     = 4'd7,
    TAMPAR              = 4'd8,
    REALIZAR_EXTRACAO   = 4'd9
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   agua_cheia_r;
  logic   agua_cheia_nxt_s;

  // State register and reservoir flag; reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      agua_cheia_r <= AGUA_INICIAL;
    end else begin
      state_r      <= state_nxt_s;
      agua_cheia_r <= agua_cheia_nxt_s;
    end
  end

  // Next-state and next-flag logic.
  always_comb begin
    state_nxt_s      = IDLE;
    agua_cheia_nxt_s = agua_cheia_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = LIGAR_MAQUINA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LIGAR_MAQUINA: begin
        state_nxt_s = VERIFICAR_AGUA;
      end
      VERIFICAR_AGUA: begin
        if (agua_cheia_r) begin
          state_nxt_s = MOER_CAFE;
        end else begin
          state_nxt_s = ENCHER_RESERVATORIO;
        end
      end
      ENCHER_RESERVATORIO: begin
        // Return to the water check, which now sees a full reservoir.
        state_nxt_s      = VERIFICAR_AGUA;
        agua_cheia_nxt_s = 1'b1;
      end
      MOER_CAFE: begin
        state_nxt_s = COLOCAR_NO_FILTRO;
      end
      COLOCAR_NO_FILTRO: begin
        state_nxt_s = PASSAR_AGITADOR;
      end
      PASSAR_AGITADOR: begin
        state_nxt_s = TAMPAR;
      end
      TAMPAR: begin
        state_nxt_s = REALIZAR_EXTRACAO;
      end
      REALIZAR_EXTRACAO: begin
        state_nxt_s = IDLE;
`ifdef CONSUMO_AGUA_EN
        // Extraction uses up the reservoir; the next brew must refill.
        agua_cheia_nxt_s = 1'b0;
`else
        agua_cheia_nxt_s = agua_cheia_r;
`endif
      end
      default: begin
        // Unused code: recover to IDLE, leave the reservoir flag alone.
        state_nxt_s      = IDLE;
        agua_cheia_nxt_s = agua_cheia_r;
      end
    endcase
  end

  assign state = state_r;

endmodule

// File: tb/tb_maquina_maluca.sv
// -----------------------------------------------------------------------------
// tb_maquina_maluca
// Table-driven bench for maquina_maluca. Two instances share clk/rst/start:
// dut0 resets with an empty reservoir, dut1 with a full one. Each table row
// holds the inputs applied for one clock and the state codes both instances
// must show after the following rising edge. Expected sequences are written
// as hex strings of state codes, one nibble per clock.
// -----------------------------------------------------------------------------
module tb_maquina_maluca;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] state0;
  logic [3:0] state1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] exp0;
    logic [3:0] exp1;
  } vec_t;

  vec_t vecs[$];

  maquina_maluca #(.AGUA_INICIAL(1'b0)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .state (state0)
  );

  maquina_maluca #(.AGUA_INICIAL(1'b1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .state (state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append n rows with fixed inputs; s0/s1 hold expected codes, first clock
  // in the most significant used nibble.
  task automatic push_run(input logic r, input logic s,
                          input logic [127:0] s0, input logic [127:0] s1,
                          input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst   = r;
      v.start = s;
      v.exp0  = s0[4*(n-1-i) +: 4];
      v.exp1  = s1[4*(n-1-i) +: 4];
      vecs.push_back(v);
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: state got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i < last; i++) begin
      rst   = vecs[i].rst;
      start = vecs[i].start;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_dut0", i), state0, vecs[i].exp0);
      check($sformatf("row%0d_dut1", i), state1, vecs[i].exp1);
    end
  endtask

  int n_phase1;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check("async_reset_t0_dut0", state0, 4'd1);
    check("async_reset_t0_dut1", state1, 4'd1);

    // Reset held two clocks, then idle with no request.
    push_run(1'b1, 1'b0, 128'h11, 128'h11, 2);
    push_run(1'b0, 1'b0, 128'h11111, 128'h11111, 5);

    // First brew: dut0 fills, dut1 already full.
    push_run(1'b0, 1'b1, 128'h2, 128'h2, 1);
    push_run(1'b0, 1'b0, 128'h343567891, 128'h356789111, 9);

    // Second brew.
    push_run(1'b0, 1'b1, 128'h2, 128'h2, 1);
`ifdef CONSUMO_AGUA_EN
    push_run(1'b0, 1'b0, 128'h343567891, 128'h343567891, 9);
    // Hold start and walk up to MOER_CAFE.
    push_run(1'b0, 1'b1, 128'h23435, 128'h23435, 5);
`else
    push_run(1'b0, 1'b0, 128'h3567891, 128'h3567891, 7);
    push_run(1'b0, 1'b1, 128'h235, 128'h235, 3);
`endif
    n_phase1 = vecs.size();

    // Reset held across one rising edge while start stays high.
    push_run(1'b1, 1'b1, 128'h1, 128'h1, 1);

    // Start held after reset release: back-to-back brews.
`ifdef CONSUMO_AGUA_EN
    push_run(1'b0, 1'b1, 128'h234356789123435678912,
                         128'h235678912343567891234, 21);
`else
    push_run(1'b0, 1'b1, 128'h2343567891235678912,
                         128'h2356789123567891235, 19);
`endif

    run_rows(0, n_phase1);

    // Both instances sit in MOER_CAFE; reset must act before the next edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_reset_midrun_dut0", state0, 4'd1);
    check("async_reset_midrun_dut1", state1, 4'd1);

    run_rows(n_phase1, vecs.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
